// File: rtl/mult_pkg.sv
// Shared definitions for the Booth multiplier datapath.
// Covers micro-op bit positions and the Booth decision-pair encodings.
package mult_pkg;

  localparam int CTL_W     = 5;
  localparam int CTL_LOAD  = 0;
  localparam int CTL_ADD   = 1;
  localparam int CTL_SUB   = 2;
  localparam int CTL_SHIFT = 3;
  localparam int CTL_CLR   = 4;

  // {Q[0], Q_m1}
  typedef enum logic [1:0] {
    BOOTH_HOLD0 = 2'b00,
    BOOTH_ADD   = 2'b01,
    BOOTH_SUB   = 2'b10,
    BOOTH_HOLD1 = 2'b11
  } booth_pair_e;

  // Micro-op a controller issues for one Booth step, given the current pair.
  function automatic logic [CTL_W-1:0] booth_step_ctl(input logic [1:0] pair);
    logic [CTL_W-1:0] ctl;
    ctl = '0;
    ctl[CTL_SHIFT] = 1'b1;
    case (pair)
      BOOTH_ADD: ctl[CTL_ADD] = 1'b1;
      BOOTH_SUB: ctl[CTL_SUB] = 1'b1;
      default:   ctl = ctl;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/mult_booth_addsub.sv
// (N+1)-bit accumulator update: ACC + sext(M), ACC - sext(M), or ACC unchanged.
// Both selects asserted together cancel out to a pass-through.
module booth_addsub #(
  parameter int N = 8
) (
  input  logic [N:0]   acc_i,
  input  logic [N-1:0] m_i,
  input  logic         add_i,
  input  logic         sub_i,
  output logic [N:0]   acc_o
);

  logic [N:0] m_sext;

  assign m_sext = {m_i[N-1], m_i};

  always_comb begin
    acc_o = acc_i;
    case ({sub_i, add_i})
      2'b01:   acc_o = acc_i + m_sext;
      2'b10:   acc_o = acc_i - m_sext;
      default: acc_o = acc_i;
    endcase
  end

endmodule

// File: rtl/mult_with_no_sm.sv
// Radix-2 Booth signed multiplier datapath driven entirely by external micro-ops.
// Register bank {ACC, Q, Q_m1, M}; Y and Q_LSB are read straight off the registers.
module mult_with_no_sm
  import mult_pkg::*;
#(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  input  logic [CTL_W-1:0] mult_control,
  output logic [1:0]       Q_LSB,
  output logic [2*N-1:0]   Y
);

  logic [N-1:0] m_q, m_d;
  logic [N-1:0] q_q, q_d;
  logic [N:0]   acc_q, acc_d;
  logic         qm1_q, qm1_d;
  logic [N:0]   acc_n;

  booth_addsub #(.N(N)) u_addsub (
    .acc_i (acc_q),
    .m_i   (m_q),
    .add_i (mult_control[CTL_ADD]),
    .sub_i (mult_control[CTL_SUB]),
    .acc_o (acc_n)
  );

  always_comb begin
    m_d   = m_q;
    q_d   = q_q;
    acc_d = acc_q;
    qm1_d = qm1_q;
    if (mult_control[CTL_CLR]) begin
      m_d   = '0;
      q_d   = '0;
      acc_d = '0;
      qm1_d = 1'b0;
    end else if (mult_control[CTL_LOAD]) begin
      m_d   = A;
      q_d   = B;
      acc_d = '0;
      qm1_d = 1'b0;
    end else if (mult_control[CTL_SHIFT]) begin
      // Arithmetic shift of {acc_n, Q, Q_m1}: sign replicated, old Q_m1 dropped.
      {acc_d, q_d, qm1_d} = {acc_n[N], acc_n, q_q};
    end else begin
      acc_d = acc_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q   <= '0;
      q_q   <= '0;
      acc_q <= '0;
      qm1_q <= 1'b0;
    end else begin
      m_q   <= m_d;
      q_q   <= q_d;
      acc_q <= acc_d;
      qm1_q <= qm1_d;
    end
  end

  assign Y     = {acc_q[N-1:0], q_q};
  assign Q_LSB = {q_q[0], qm1_q};

endmodule

// File: tb/tb_mult_with_no_sm.sv
// Directed checks of the Booth datapath with the bench acting as the external controller.
module tb_mult_with_no_sm;
  import mult_pkg::*;

  localparam int N = 8;

  logic             clk;
  logic             rst;
  logic [N-1:0]     A;
  logic [N-1:0]     B;
  logic [CTL_W-1:0] mult_control;
  logic [1:0]       Q_LSB;
  logic [2*N-1:0]   Y;

  int n_vec;
  int n_bad;

  mult_with_no_sm #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .A            (A),
    .B            (B),
    .mult_control (mult_control),
    .Q_LSB        (Q_LSB),
    .Y            (Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %04h expected %04h", tag, got, exp);
    end else begin
      $display("ok   %s: %04h", tag, got);
    end
  endtask

  // Apply one micro-op across a rising edge; return 1 ns after the edge.
  task automatic op(input logic [CTL_W-1:0] ctl);
    mult_control = ctl;
    @(posedge clk);
    #1;
    mult_control = '0;
  endtask

  task automatic load(input logic [N-1:0] a, input logic [N-1:0] b);
    A = a;
    B = b;
    op(5'b00001);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) op(booth_step_ctl(Q_LSB));
  endtask

  task automatic run(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                     input logic [15:0] exp);
    load(a, b);
    steps(N);
    chk(tag, Y, exp);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b0;
    A = 8'h5A;
    B = 8'hC3;
    mult_control = 5'b01011;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_y", Y, 16'h0000);
    chk("rst_qlsb", {14'd0, Q_LSB}, 16'h0000);
    mult_control = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_y", Y, 16'h0000);
    chk("idle_qlsb", {14'd0, Q_LSB}, 16'h0000);

    load(8'd3, 8'd5);
    chk("first_qlsb", {14'd0, Q_LSB}, 16'h0002);
    steps(N);
    chk("3x5", Y, 16'h000F);
    op(5'b00000);
    chk("3x5_hold", Y, 16'h000F);

    run("m3x5", 8'hFD, 8'd5, 16'hFFF1);
    run("5xm3", 8'd5, 8'hFD, 16'hFFF1);
    run("m128xm128", 8'h80, 8'h80, 16'h4000);
    run("m128x127", 8'h80, 8'h7F, 16'hC080);
    run("127x127", 8'h7F, 8'h7F, 16'h3F01);

    load(8'd1, 8'd0);
    op(5'b00010);
    chk("add_only", Y, 16'h0100);
    op(5'b01000);
    chk("shift_only", Y, 16'h0080);
    chk("shift_qlsb", {14'd0, Q_LSB}, 16'h0000);
    op(5'b00110);
    chk("add_sub_nop", Y, 16'h0080);
    load(8'd1, 8'd0);
    op(5'b00100);
    chk("sub_only", Y, 16'hFF00);

    load(8'd3, 8'd5);
    steps(4);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_y", Y, 16'h0000);
    chk("async_rst_qlsb", {14'd0, Q_LSB}, 16'h0000);
    @(negedge clk);
    rst = 1'b1;

    load(8'd7, 8'd9);
    steps(3);
    op(5'b11110);
    chk("clr_mid", Y, 16'h0000);

    A = 8'd2;
    B = 8'd1;
    op(5'b00011);
    chk("load_add", Y, 16'h0001);
    chk("load_add_qlsb", {14'd0, Q_LSB}, 16'h0002);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
